// File: rtl/serial_word_deser.sv
// Serial-to-parallel receive stage: framed words (start=1, WIDTH data MSB first,
// stop=0) land in a one-word valid/ready holding register with sticky error flags.
module serial_word_deser #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             bit_en,
  input  logic             sdi,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             busy,
  output logic             frame_err,
  output logic             overrun,
  input  logic             clr_err
);

  typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [WIDTH-1:0]   m_data_q;
  logic               m_valid_q;
  logic               frame_err_q;
  logic               overrun_q;
  logic               take;

  assign shreg_d = {shreg_q[WIDTH-2:0], sdi};
  // holding register can accept a word if empty or being drained this edge
  assign take    = !m_valid_q || m_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shreg_q     <= '0;
      m_data_q    <= '0;
      m_valid_q   <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      if (m_valid_q && m_ready) m_valid_q <= 1'b0;
      // flag sets below come later in the block, so a coincident set wins
      if (clr_err) begin
        frame_err_q <= 1'b0;
        overrun_q   <= 1'b0;
      end
      if (bit_en) begin
        case (state_q)
          IDLE: begin
            if (sdi) begin
              state_q <= DATA;
              cnt_q   <= '0;
            end
          end
          DATA: begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH-1)) state_q <= STOP;
          end
          STOP: begin
            if (!sdi) begin
              if (take) begin
                m_data_q  <= shreg_q;
                m_valid_q <= 1'b1;
              end else begin
                overrun_q <= 1'b1;
              end
            end else begin
              frame_err_q <= 1'b1;
            end
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign m_data    = m_data_q;
  assign m_valid   = m_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != IDLE);

endmodule
